// File: rtl/spi_ram_pkg.sv
// ============================================================================
// Module   : spi_ram_pkg
// Brief    : Shared FSM state encoding and opcode constants for the SPI RAM
//            slave and its testbench.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_ram_pkg;

    // Transaction-level states of the slave
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WR_ADDR = 3'd2,
        WR_DATA = 3'd3,
        RD_ADDR = 3'd4,
        RD_WAIT = 3'd5,
        RD_DATA = 3'd6,
        HOLD    = 3'd7
    } state_t;

    // Two-bit opcode received MSB first right after the frame opens
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

`default_nettype wire

// File: rtl/spi_ram_mem.sv
// ============================================================================
// Module   : spi_ram_mem
// Brief    : Single-port synchronous RAM, DATA_W x MEM_DEPTH, registered read.
//            Contents are never reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port and registered read share one address; the controller never
    // asserts both enables on the same edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/spi_ram_slave_p.sv
// ============================================================================
// Module   : spi_ram_slave_p
// Brief    : Clock-sampled SPI slave fronting a small RAM. Each SS_n-low frame
//            carries a 2-bit opcode followed by an address load, a write burst
//            or a gap-free read burst. Out-of-range addresses raise a sticky
//            addr_err and disable the affected pointer until reloaded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_ram_slave_p #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic addr_err
);

    import spi_ram_pkg::*;

    localparam int c_MAX_W  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int c_CNT_W  = $clog2(c_MAX_W);
    localparam int c_DIDX_W = $clog2(DATA_W);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_W - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]    c_MEM_LAST  = (ADDR_W + 1)'(MEM_DEPTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    // Only the bits preceding the current MOSI bit need storing
    logic [c_MAX_W-2:0]   r_shift;
    logic [c_MAX_W-1:0]   w_shift_nxt;
    logic                 r_op_msb;

    logic [ADDR_W-1:0]    r_wr_addr;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic                 r_wr_bad;
    logic                 r_rd_bad;
    logic                 r_rd_zero;
    logic                 r_addr_err;
    logic                 r_miso;

    logic                 w_shift_en;
    logic                 w_op_cap;
    logic                 w_wr_load;
    logic                 w_rd_load;
    logic                 w_wr_word;
    logic                 w_rd_fetch;
    logic                 w_rd_inc;
    logic                 w_miso_nxt;

    logic [ADDR_W-1:0]    w_load_addr;
    logic                 w_load_bad;
    logic [ADDR_W-1:0]    w_mem_addr;
    logic                 w_mem_we;
    logic                 w_mem_re;
    logic [DATA_W-1:0]    w_mem_rdata;
    logic [DATA_W-1:0]    w_rd_word;
    logic [c_DIDX_W-1:0]  w_rd_idx;

    // Pointer increment with wrap at the last implemented word
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if ({1'b0, a} == c_MEM_LAST) begin
            next_addr = '0;
        end else begin
            next_addr = a + ADDR_W'(1);
        end
    endfunction

    assign w_shift_nxt = {r_shift, MOSI};
    assign w_load_addr = w_shift_nxt[ADDR_W-1:0];
    assign w_load_bad  = ({1'b0, w_load_addr} > c_MEM_LAST);

    // A disabled pointer never touches the array; reads of it come back as zero
    assign w_mem_we   = w_wr_word & ~r_wr_bad;
    assign w_mem_re   = w_rd_fetch & ~r_rd_bad;
    assign w_mem_addr = w_wr_word ? r_wr_addr
                      : (w_rd_inc ? next_addr(r_rd_addr) : r_rd_addr);

    // The RAM read register doubles as the outgoing word; bits are picked MSB first
    assign w_rd_word = r_rd_zero ? '0 : w_mem_rdata;
    assign w_rd_idx  = c_DIDX_W'(c_DATA_LAST - r_bit_cnt);

    // State and bit counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
        end
    end

    // Next-state decode and per-edge datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_shift_en  = 1'b0;
        w_op_cap    = 1'b0;
        w_wr_load   = 1'b0;
        w_rd_load   = 1'b0;
        w_wr_word   = 1'b0;
        w_rd_fetch  = 1'b0;
        w_rd_inc    = 1'b0;
        w_miso_nxt  = 1'b0;
        if (SS_n) begin
            // Frame closed: any partial word or address is dropped
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = CMD;
                    w_cnt_nxt   = '0;
                end
                CMD: begin
                    if (r_bit_cnt == '0) begin
                        w_op_cap  = 1'b1;
                        w_cnt_nxt = c_CNT_ONE;
                    end else begin
                        w_cnt_nxt = '0;
                        case ({r_op_msb, MOSI})
                            OP_WR_ADDR: w_state_nxt = WR_ADDR;
                            OP_WR_DATA: w_state_nxt = WR_DATA;
                            OP_RD_ADDR: w_state_nxt = RD_ADDR;
                            default:    w_state_nxt = RD_WAIT;
                        endcase
                    end
                end
                WR_ADDR, RD_ADDR: begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_ADDR_LAST) begin
                        w_wr_load   = (r_state == WR_ADDR);
                        w_rd_load   = (r_state == RD_ADDR);
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                    end
                end
                WR_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_DATA_LAST) begin
                        w_wr_word = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                    end
                end
                RD_WAIT: begin
                    w_rd_fetch  = 1'b1;
                    w_state_nxt = RD_DATA;
                    w_cnt_nxt   = '0;
                end
                RD_DATA: begin
                    w_miso_nxt = w_rd_word[w_rd_idx];
                    if (r_bit_cnt == c_DATA_LAST) begin
                        // Prefetch the following word while its predecessor's LSB goes out
                        w_rd_fetch = 1'b1;
                        w_rd_inc   = 1'b1;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                    end
                end
                HOLD: begin
                    w_state_nxt = HOLD;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Shift-in, opcode MSB, address pointers, error flag and MISO register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_op_msb   <= 1'b0;
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_wr_bad   <= 1'b0;
            r_rd_bad   <= 1'b0;
            r_rd_zero  <= 1'b0;
            r_addr_err <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            if (w_shift_en) begin
                r_shift <= w_shift_nxt[c_MAX_W-2:0];
            end
            if (w_op_cap) begin
                r_op_msb <= MOSI;
            end
            if (w_wr_load) begin
                r_wr_addr <= w_load_addr;
                r_wr_bad  <= w_load_bad;
            end else if (w_wr_word) begin
                r_wr_addr <= next_addr(r_wr_addr);
            end
            if (w_rd_load) begin
                r_rd_addr <= w_load_addr;
                r_rd_bad  <= w_load_bad;
            end else if (w_rd_inc) begin
                r_rd_addr <= next_addr(r_rd_addr);
            end
            if (w_rd_fetch) begin
                r_rd_zero <= r_rd_bad;
            end
            if ((w_wr_load || w_rd_load) && w_load_bad) begin
                r_addr_err <= 1'b1;
            end
            r_miso <= w_miso_nxt;
        end
    end

    spi_ram_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (w_shift_nxt[DATA_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

    assign MISO     = r_miso;
    assign busy     = (r_state != IDLE);
    assign addr_err = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_slave_p.sv
// ============================================================================
// Module   : tb_spi_ram_slave_p
// Brief    : Self-checking bench for spi_ram_slave_p. Two instances (256 and
//            200 words) share one SPI stimulus; a frame-level model tracks
//            memory, pointers and error flags for each.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_ram_slave_p;

    logic clk = 1'b0;
    logic rst;
    logic ss_n;
    logic mosi;
    logic miso0, busy0, err0;
    logic miso1, busy1, err1;

    int    checks = 0;
    int    errors = 0;
    string cur_tag = "reset";

    // Frame-level reference model, index 0 = 256 words, 1 = 200 words
    int         depth [2] = '{256, 200};
    logic [7:0] mm [2][256];
    int         wa [2];
    int         ra [2];
    bit         wbad [2];
    bit         rbad [2];
    bit         aerr [2];

    bit tx_q[$];
    bit exp0_q[$];
    bit exp1_q[$];
    bit rx0_q[$];
    bit rx1_q[$];

    spi_ram_slave_p #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256)) u_dut0 (
        .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
        .MISO(miso0), .busy(busy0), .addr_err(err0)
    );

    spi_ram_slave_p #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) u_dut1 (
        .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
        .MISO(miso1), .busy(busy1), .addr_err(err1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur_tag, tag, obs, exp);
        end
    endtask

    function automatic int inc_addr(input int d, input int a);
        return (a == depth[d] - 1) ? 0 : ((a + 1) % 256);
    endfunction

    function automatic int q_val(input int start, input int nb);
        int v = 0;
        for (int i = 0; i < nb; i++) v = (v << 1) | int'(tx_q[start + i]);
        return v;
    endfunction

    function automatic void push_exp(input int d, input bit b);
        if (d == 0) exp0_q.push_back(b);
        else        exp1_q.push_back(b);
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tx_q.push_back(b[i]);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) tx_q.push_back(1'($urandom));
    endtask

    function automatic logic [7:0] rx_byte(input int d, input int b);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++)
            v = {v[6:0], (d == 0) ? rx0_q[1 + 8*b + i] : rx1_q[1 + 8*b + i]};
        return v;
    endfunction

    // Expected MISO per payload edge plus the effect of the whole frame
    task automatic model_frame(input int d, input logic [1:0] op);
        int n;
        int a;
        int addr;
        logic [7:0] val;
        n = tx_q.size();
        case (op)
            2'b00, 2'b10: begin
                for (int k = 0; k < n; k++) push_exp(d, 1'b0);
                if (n >= 8) begin
                    a = q_val(0, 8);
                    if (op == 2'b00) begin wa[d] = a; wbad[d] = (a >= depth[d]); end
                    else             begin ra[d] = a; rbad[d] = (a >= depth[d]); end
                    if (a >= depth[d]) aerr[d] = 1'b1;
                end
            end
            2'b01: begin
                for (int k = 0; k < n; k++) push_exp(d, 1'b0);
                for (int w = 0; w < n / 8; w++) begin
                    if (!wbad[d]) mm[d][wa[d]] = 8'(q_val(w * 8, 8));
                    wa[d] = inc_addr(d, wa[d]);
                end
            end
            default: begin
                if (n > 0) push_exp(d, 1'b0);
                addr = ra[d];
                for (int j = 0; j < n - 1; j++) begin
                    val = rbad[d] ? 8'h00 : mm[d][addr];
                    push_exp(d, val[7 - (j % 8)]);
                    if (j % 8 == 7) addr = inc_addr(d, addr);
                end
                ra[d] = addr;
            end
        endcase
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            wa[d] = 0; ra[d] = 0; wbad[d] = 0; rbad[d] = 0; aerr[d] = 0;
        end
    endtask

    // One SS_n-low frame: open edge, two opcode edges, tx_q payload, close edge
    task automatic frame(input logic [1:0] op);
        int n;
        n = tx_q.size();
        exp0_q.delete(); exp1_q.delete(); rx0_q.delete(); rx1_q.delete();
        model_frame(0, op);
        model_frame(1, op);
        @(negedge clk); ss_n = 1'b0; mosi = 1'($urandom);
        @(posedge clk); #1;
        chk("busy0_open", busy0, 1'b1);
        chk("busy1_open", busy1, 1'b1);
        for (int i = 1; i >= 0; i--) begin
            @(negedge clk); mosi = op[i];
            @(posedge clk); #1;
            chk("miso0_op", miso0, 1'b0);
            chk("miso1_op", miso1, 1'b0);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk); mosi = tx_q[k];
            @(posedge clk); #1;
            chk("miso0", miso0, exp0_q[k]);
            chk("miso1", miso1, exp1_q[k]);
            chk("busy0", busy0, 1'b1);
            rx0_q.push_back(miso0);
            rx1_q.push_back(miso1);
        end
        @(negedge clk); ss_n = 1'b1; mosi = 1'($urandom);
        @(posedge clk); #1;
        chk("busy0_close", busy0, 1'b0);
        chk("busy1_close", busy1, 1'b0);
        chk("miso0_close", miso0, 1'b0);
        chk("miso1_close", miso1, 1'b0);
        chk("err0", err0, aerr[0]);
        chk("err1", err1, aerr[1]);
        tx_q.delete();
    endtask

    initial begin
        logic [1:0] rop;
        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0;
        model_reset();
        #1;
        chk("miso0_rst", miso0, 1'b0);
        chk("busy0_rst", busy0, 1'b0);
        chk("err0_rst", err0, 1'b0);
        chk("busy1_rst", busy1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fill every word so later reads compare against known contents
        cur_tag = "fill";
        push_byte(8'h00); frame(2'b00);
        for (int i = 0; i < 256; i++) push_byte(8'($urandom));
        frame(2'b01);

        // Address load then two-word burst; third word lands at 0x12
        cur_tag = "write_burst";
        push_byte(8'h10); frame(2'b00);
        push_byte(8'hA5); push_byte(8'h5A); frame(2'b01);
        push_byte(8'h3C); frame(2'b01);

        // Read back contiguously, first data bit the edge after RD_WAIT
        cur_tag = "read_burst";
        push_byte(8'h10); frame(2'b10);
        push_rand(25); frame(2'b11);
        chk("byte0", rx_byte(0, 0), 8'hA5);
        chk("byte1", rx_byte(0, 1), 8'h5A);
        chk("byte2", rx_byte(0, 2), 8'h3C);
        chk("byte0_d200", rx_byte(1, 0), 8'hA5);

        // Frame cut after 5 bits of a word: nothing written, next frames normal
        cur_tag = "partial_word";
        push_rand(5); frame(2'b01);
        push_byte(8'h13); frame(2'b10);
        push_rand(9); frame(2'b11);

        // Out-of-range write address on the 200-word instance
        cur_tag = "addr_err";
        push_byte(8'hC8); frame(2'b00);
        chk("err1_set", err1, 1'b1);
        chk("err0_clear", err0, 1'b0);
        push_byte(8'h77); push_byte(8'h88); frame(2'b01);
        push_byte(8'hC8); frame(2'b10);
        push_rand(17); frame(2'b11);
        chk("d200_zero", rx_byte(1, 0), 8'h00);
        chk("d256_c8", rx_byte(0, 0), 8'h77);
        push_byte(8'h20); frame(2'b00);
        chk("err1_sticky", err1, 1'b1);

        // Write pointer wrap from the top of the 256-word array
        cur_tag = "wrap";
        push_byte(8'hFF); frame(2'b00);
        push_byte(8'h11); push_byte(8'h22); frame(2'b01);
        push_byte(8'hFF); frame(2'b10);
        push_rand(17); frame(2'b11);
        chk("wrap_ff", rx_byte(0, 0), 8'h11);
        chk("wrap_00", rx_byte(0, 1), 8'h22);

        // Asynchronous reset between edges during RD_DATA
        cur_tag = "rst_mid_read";
        push_byte(8'h10); frame(2'b10);
        @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
        @(posedge clk);
        @(negedge clk); mosi = 1'b1;
        @(posedge clk);
        @(negedge clk); mosi = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        chk("miso0_msb", miso0, 1'b1);
        chk("miso1_msb", miso1, mm[1][16][7]);
        #2 rst = 1'b1;
        #1;
        chk("miso0_async", miso0, 1'b0);
        chk("busy0_async", busy0, 1'b0);
        chk("miso1_async", miso1, 1'b0);
        chk("busy1_async", busy1, 1'b0);
        chk("err1_async", err1, 1'b0);
        model_reset();
        @(negedge clk); ss_n = 1'b1;
        @(negedge clk); rst = 1'b0;
        push_rand(17); frame(2'b11);

        // Random frames against the model
        cur_tag = "random";
        for (int f = 0; f < 40; f++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop == 2'b00 || rop == 2'b10) push_rand(int'($urandom_range(0, 12)));
            else                              push_rand(int'($urandom_range(0, 34)));
            frame(rop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_ram_slave_p.md
SPI_RAM_SLAVE_P -- requirements
Module: spi_ram_slave_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8: memory word width and SPI data payload width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8: address payload width in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 256: number of words, 2 <= MEM_DEPTH <= 2**ADDR_W.
REQ-004 SHALL have port clk  in  1  single clock; every transition happens on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port SS_n  in  1  slave select, active-low; a low period frames one transaction.
REQ-007 SHALL have port MOSI  in  1  serial data in, MSB first, sampled on clk rising edge.
REQ-008 SHALL have port MISO  out  1  serial data out, MSB first, registered.
REQ-009 SHALL have port busy  out  1  high while the state machine is not IDLE.
REQ-010 SHALL have port addr_err  out  1  sticky flag: an address >= MEM_DEPTH was loaded.

Function
REQ-011 SHALL implement the states IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_DATA, HOLD.
REQ-012 SHALL leave IDLE for CMD on the first edge where SS_n=0; MOSI is not sampled on that edge.
REQ-013 SHALL capture a 2-bit opcode on the next two edges (MSB first): 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA (via RD_WAIT).
REQ-014 SHALL in WR_ADDR/RD_ADDR shift ADDR_W bits, load wr_addr/rd_addr on the last bit edge, then enter HOLD; HOLD ignores MOSI.
REQ-015 SHALL in WR_DATA shift DATA_W bits per word, write mem[wr_addr] on the last bit edge, and post-increment wr_addr; the burst continues while SS_n stays low.
REQ-016 SHALL spend exactly one edge in RD_WAIT, registering mem[rd_addr] into the shift register, then enter RD_DATA.
REQ-017 SHALL in RD_DATA drive MISO with one bit per edge, MSB first; on the edge driving a word's LSB it SHALL prefetch mem[rd_addr+1] and post-increment rd_addr, so the next word follows with no gap.
REQ-018 SHALL wrap both addresses from MEM_DEPTH-1 to 0 on increment.
REQ-019 SHALL, when a loaded address is >= MEM_DEPTH, set addr_err, suppress writes, and return all-zero read data until a valid address is loaded.
REQ-020 SHALL, when SS_n rises in any state, return to IDLE on that edge, discard any partial word (no write, no address load), and drive MISO=0.
REQ-021 SHALL drive MISO=0 in every state except RD_DATA.
REQ-022 SHALL keep wr_addr and rd_addr across transactions; a transaction never clears them.
REQ-023 SHALL clear addr_err only on reset.

Reset
REQ-024 SHALL on rst force state=IDLE, MISO=0, busy=0, addr_err=0, wr_addr=0, rd_addr=0, and clear the shift counters immediately, without waiting for clk.
REQ-025 SHALL not reset memory contents; reset asserted mid-transaction aborts it with no write.

Structure
REQ-026 SHALL place the state enum and opcode constants (OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11) in shared package spi_ram_pkg.
REQ-027 SHALL instantiate exactly one sub-module, spi_ram_mem: a synchronous single-port DATA_W x MEM_DEPTH array with registered read.

Verification (DATA_W=8, ADDR_W=8, MEM_DEPTH=256)
REQ-028 SHALL cover: frame 00+0x10, then frame 01+0xA5,0x5A -> mem[0x10]=0xA5, mem[0x11]=0x5A, wr_addr=0x12.
REQ-029 SHALL cover: frame 10+0x10, then frame 11 for 16 data edges -> MISO=0xA5 then 0x5A, contiguous, starting the edge after RD_WAIT.
REQ-030 SHALL cover: wr_addr=0xFF, burst of 0x11,0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22.
REQ-031 SHALL cover: SS_n raised after 5 bits of a WR_DATA word -> no write, busy=0 on that edge, next frame decodes normally.
REQ-032 SHALL cover: MEM_DEPTH=200, load write address 0xC8 -> addr_err=1, following data not written, held through later frames until rst.
REQ-033 SHALL cover: rst pulsed mid-RD_DATA between edges -> MISO=0, busy=0 asynchronously, rd_addr=0, memory unchanged.
